// File: rtl/ysyx_23060184_axi_arbiter.sv
// rtl/ysyx_23060184_axi_arbiter.sv - IFU/LSU arbiter onto one AXI4 master port with watchdog
module ysyx_23060184_axi_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                      clk,
    input  logic                      resetn,
    // IFU
    input  logic                      i_req,
    input  logic [DATA_WIDTH-1:0]     i_araddr,
    input  logic                      i_arvalid,
    input  logic [2:0]                i_arsize,
    input  logic [7:0]                i_arlen,
    input  logic [1:0]                i_arburst,
    output logic                      i_arready,
    output logic [DATA_WIDTH-1:0]     i_rdata,
    output logic [1:0]                i_rresp,
    output logic                      i_rvalid,
    output logic                      i_rlast,
    input  logic                      i_rready,
    output logic                      i_grant,
    // LSU
    input  logic                      d_req,
    input  logic                      d_wen,
    input  logic [DATA_WIDTH-1:0]     d_araddr,
    input  logic                      d_arvalid,
    input  logic [2:0]                d_arsize,
    input  logic [7:0]                d_arlen,
    input  logic [1:0]                d_arburst,
    output logic                      d_arready,
    output logic [DATA_WIDTH-1:0]     d_rdata,
    output logic [1:0]                d_rresp,
    output logic                      d_rvalid,
    output logic                      d_rlast,
    input  logic                      d_rready,
    input  logic [DATA_WIDTH-1:0]     d_awaddr,
    input  logic                      d_awvalid,
    input  logic [2:0]                d_awsize,
    output logic                      d_awready,
    input  logic [DATA_WIDTH-1:0]     d_wdata,
    input  logic [DATA_WIDTH/8-1:0]   d_wstrb,
    input  logic                      d_wvalid,
    input  logic                      d_wlast,
    output logic                      d_wready,
    output logic [1:0]                d_bresp,
    output logic                      d_bvalid,
    input  logic                      d_bready,
    output logic                      d_grant,
    // shared master port
    output logic [DATA_WIDTH-1:0]     m_araddr,
    output logic                      m_arvalid,
    output logic [2:0]                m_arsize,
    output logic [7:0]                m_arlen,
    output logic [1:0]                m_arburst,
    output logic [ID_WIDTH-1:0]       m_arid,
    input  logic                      m_arready,
    input  logic [DATA_WIDTH-1:0]     m_rdata,
    input  logic [1:0]                m_rresp,
    input  logic                      m_rvalid,
    input  logic                      m_rlast,
    input  logic [ID_WIDTH-1:0]       m_rid,
    output logic                      m_rready,
    output logic [DATA_WIDTH-1:0]     m_awaddr,
    output logic                      m_awvalid,
    output logic [2:0]                m_awsize,
    output logic [ID_WIDTH-1:0]       m_awid,
    input  logic                      m_awready,
    output logic [DATA_WIDTH-1:0]     m_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_wstrb,
    output logic                      m_wvalid,
    output logic                      m_wlast,
    input  logic                      m_wready,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    input  logic [ID_WIDTH-1:0]       m_bid,
    output logic                      m_bready,
    output logic                      timeout
);
    typedef enum logic [1:0] {ST_IDLE, ST_GNT_I, ST_GNT_D, ST_ERR} state_t;

    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

    state_t     r_state;
    logic       r_i_grant, r_d_grant;
    logic       r_owner;        // 0 = IFU, 1 = LSU
    logic       r_wen;
    logic       r_last_owner;
    logic [7:0] r_cnt;
    logic       r_timeout;

    logic w_rd_done, w_wr_done, w_done, w_pick_i, w_err_ack, w_unused;

    assign w_unused  = ^{m_rid, m_bid};
    assign w_rd_done = m_rvalid & m_rready & m_rlast;
    assign w_wr_done = m_bvalid & m_bready;
    assign w_done    = r_wen ? w_wr_done : w_rd_done;
    assign w_pick_i  = i_req & (~d_req | r_last_owner);
    assign w_err_ack = r_owner ? (r_wen ? d_bready : d_rready) : i_rready;

    assign i_grant = r_i_grant;
    assign d_grant = r_d_grant;
    assign timeout = r_timeout;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_i_grant    <= 1'b0;
            r_d_grant    <= 1'b0;
            r_owner      <= 1'b1;
            r_wen        <= 1'b0;
            r_last_owner <= 1'b1;
            r_cnt        <= 8'd0;
            r_timeout    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= 8'd0;
                    if (w_pick_i) begin
                        r_state   <= ST_GNT_I;
                        r_i_grant <= 1'b1;
                        r_owner   <= 1'b0;
                        r_wen     <= 1'b0;
                    end else if (d_req) begin
                        r_state   <= ST_GNT_D;
                        r_d_grant <= 1'b1;
                        r_owner   <= 1'b1;
                        r_wen     <= d_wen;
                    end
                end
                ST_GNT_I, ST_GNT_D: begin
                    // completion is tested first so it beats a same-cycle watchdog expiry
                    if (w_done) begin
                        r_state      <= ST_IDLE;
                        r_i_grant    <= 1'b0;
                        r_d_grant    <= 1'b0;
                        r_last_owner <= r_owner;
                    end else if (r_cnt == LP_CNT_LAST) begin
                        r_state   <= ST_ERR;
                        r_i_grant <= 1'b0;
                        r_d_grant <= 1'b0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_ERR: begin
                    if (w_err_ack) begin
                        r_state      <= ST_IDLE;
                        r_last_owner <= r_owner;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        m_araddr  = '0;  m_arvalid = 1'b0; m_arsize = '0; m_arlen = '0; m_arburst = '0;
        m_arid    = '0;
        m_awaddr  = '0;  m_awvalid = 1'b0; m_awsize = '0; m_awid = ID_WIDTH'(1);
        m_wdata   = '0;  m_wstrb   = '0;   m_wvalid = 1'b0; m_wlast = 1'b0;
        m_rready  = 1'b0; m_bready = 1'b0;
        i_arready = 1'b0; i_rdata = '0; i_rresp = 2'b00; i_rvalid = 1'b0; i_rlast = 1'b0;
        d_arready = 1'b0; d_rdata = '0; d_rresp = 2'b00; d_rvalid = 1'b0; d_rlast = 1'b0;
        d_awready = 1'b0; d_wready = 1'b0; d_bresp = 2'b00; d_bvalid = 1'b0;
        case (r_state)
            ST_GNT_I: begin
                m_araddr = i_araddr; m_arvalid = i_arvalid; m_arsize = i_arsize;
                m_arlen  = i_arlen;  m_arburst = i_arburst; i_arready = m_arready;
                i_rdata  = m_rdata;  i_rresp   = m_rresp;   i_rvalid  = m_rvalid;
                i_rlast  = m_rlast;  m_rready  = i_rready;
            end
            ST_GNT_D: begin
                if (r_wen) begin
                    m_awaddr = d_awaddr; m_awvalid = d_awvalid; m_awsize = d_awsize;
                    d_awready = m_awready;
                    m_wdata  = d_wdata;  m_wstrb = d_wstrb; m_wvalid = d_wvalid;
                    m_wlast  = d_wlast;  d_wready = m_wready;
                    d_bresp  = m_bresp;  d_bvalid = m_bvalid; m_bready = d_bready;
                end else begin
                    m_araddr = d_araddr; m_arvalid = d_arvalid; m_arsize = d_arsize;
                    m_arlen  = d_arlen;  m_arburst = d_arburst; d_arready = m_arready;
                    m_arid   = ID_WIDTH'(1);
                    d_rdata  = m_rdata;  d_rresp = m_rresp; d_rvalid = m_rvalid;
                    d_rlast  = m_rlast;  m_rready = d_rready;
                end
            end
            ST_ERR: begin
                // slave is ignored; drain anything it still returns
                m_rready = 1'b1;
                m_bready = 1'b1;
                if (!r_owner) begin
                    i_rvalid = 1'b1; i_rresp = 2'b10; i_rlast = 1'b1;
                end else if (r_wen) begin
                    d_bvalid = 1'b1; d_bresp = 2'b10;
                end else begin
                    d_rvalid = 1'b1; d_rresp = 2'b10; d_rlast = 1'b1;
                end
            end
            default: begin
                m_rready = 1'b1;
                m_bready = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_ysyx_23060184_axi_arbiter.sv
// tb/tb_ysyx_23060184_axi_arbiter.sv - directed bench for the IFU/LSU AXI arbiter
module tb_ysyx_23060184_axi_arbiter;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic i_req, i_arvalid, i_arready, i_rvalid, i_rlast, i_rready, i_grant;
    logic [31:0] i_araddr, i_rdata;
    logic [2:0]  i_arsize;
    logic [7:0]  i_arlen;
    logic [1:0]  i_arburst, i_rresp;
    logic d_req, d_wen, d_arvalid, d_arready, d_rvalid, d_rlast, d_rready;
    logic [31:0] d_araddr, d_rdata, d_awaddr, d_wdata;
    logic [2:0]  d_arsize, d_awsize;
    logic [7:0]  d_arlen;
    logic [1:0]  d_arburst, d_rresp, d_bresp;
    logic d_awvalid, d_awready, d_wvalid, d_wlast, d_wready, d_bvalid, d_bready, d_grant;
    logic [3:0]  d_wstrb;
    logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
    logic m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
    logic [2:0]  m_arsize, m_awsize;
    logic [7:0]  m_arlen;
    logic [1:0]  m_arburst, m_rresp, m_bresp;
    logic [3:0]  m_arid, m_rid, m_awid, m_bid, m_wstrb;
    logic m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid, m_bready, timeout;

    logic        slave_en;
    logic [31:0] rd_data;
    int checks = 0;
    int failures = 0;
    int n;
    logic [7:0] exp_ig, exp_dg;

    always #5 clk = ~clk;

    ysyx_23060184_axi_arbiter dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_araddr(i_araddr), .i_arvalid(i_arvalid), .i_arsize(i_arsize),
        .i_arlen(i_arlen), .i_arburst(i_arburst), .i_arready(i_arready), .i_rdata(i_rdata),
        .i_rresp(i_rresp), .i_rvalid(i_rvalid), .i_rlast(i_rlast), .i_rready(i_rready),
        .i_grant(i_grant),
        .d_req(d_req), .d_wen(d_wen), .d_araddr(d_araddr), .d_arvalid(d_arvalid),
        .d_arsize(d_arsize), .d_arlen(d_arlen), .d_arburst(d_arburst), .d_arready(d_arready),
        .d_rdata(d_rdata), .d_rresp(d_rresp), .d_rvalid(d_rvalid), .d_rlast(d_rlast),
        .d_rready(d_rready), .d_awaddr(d_awaddr), .d_awvalid(d_awvalid), .d_awsize(d_awsize),
        .d_awready(d_awready), .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wvalid(d_wvalid),
        .d_wlast(d_wlast), .d_wready(d_wready), .d_bresp(d_bresp), .d_bvalid(d_bvalid),
        .d_bready(d_bready), .d_grant(d_grant),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arsize(m_arsize), .m_arlen(m_arlen),
        .m_arburst(m_arburst), .m_arid(m_arid), .m_arready(m_arready), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rid(m_rid),
        .m_rready(m_rready), .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awsize(m_awsize),
        .m_awid(m_awid), .m_awready(m_awready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wready(m_wready), .m_bresp(m_bresp),
        .m_bvalid(m_bvalid), .m_bid(m_bid), .m_bready(m_bready), .timeout(timeout)
    );

    // single-beat slave: R one cycle after an AR handshake, B one cycle after AW+W
    always @(posedge clk) begin
        if (!resetn) begin
            m_rvalid <= 1'b0;
            m_bvalid <= 1'b0;
        end else begin
            if (m_rvalid && m_rready) m_rvalid <= 1'b0;
            else if (slave_en && m_arvalid && m_arready) begin
                m_rvalid <= 1'b1; m_rdata <= rd_data; m_rlast <= 1'b1; m_rresp <= 2'b00;
            end
            if (m_bvalid && m_bready) m_bvalid <= 1'b0;
            else if (slave_en && m_awvalid && m_wvalid) begin
                m_bvalid <= 1'b1; m_bresp <= 2'b00;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        i_req = 0; i_araddr = 0; i_arvalid = 0; i_arsize = 3'd2; i_arlen = 0; i_arburst = 2'b01;
        i_rready = 1;
        d_req = 0; d_wen = 0; d_araddr = 0; d_arvalid = 0; d_arsize = 3'd2; d_arlen = 0;
        d_arburst = 2'b01; d_rready = 1; d_awaddr = 0; d_awvalid = 0; d_awsize = 3'd2;
        d_wdata = 0; d_wstrb = 0; d_wvalid = 0; d_wlast = 0; d_bready = 1;
        m_arready = 1; m_awready = 1; m_wready = 1; m_rid = 0; m_bid = 1;
        m_rdata = 0; m_rresp = 0; m_rlast = 0; m_bresp = 0; m_rvalid = 0; m_bvalid = 0;
        slave_en = 1; rd_data = 32'h0000_0413;

        // reset state
        step(); step();
        @(negedge clk);
        check_eq("rst_i_grant", i_grant, 0);
        check_eq("rst_d_grant", d_grant, 0);
        check_eq("rst_timeout", timeout, 0);
        check_eq("rst_m_rready", m_rready, 1);
        check_eq("rst_m_bready", m_bready, 1);
        check_eq("rst_m_arvalid", m_arvalid, 0);
        step(); resetn = 1;

        // IFU read: grant one cycle after request
        step();
        i_req = 1; i_araddr = 32'h8000_0000; i_arvalid = 1;
        @(negedge clk);
        check_eq("ifu_grant_latency", i_grant, 0);
        step();
        @(negedge clk);
        check_eq("ifu_grant", i_grant, 1);
        check_eq("ifu_m_araddr", m_araddr, 32'h8000_0000);
        check_eq("ifu_m_arvalid", m_arvalid, 1);
        check_eq("ifu_m_arid", m_arid, 0);
        check_eq("ifu_d_arready", d_arready, 0);
        check_eq("ifu_m_awvalid", m_awvalid, 0);
        step(); i_arvalid = 0; i_req = 0;
        @(negedge clk);
        check_eq("ifu_rvalid", i_rvalid, 1);
        check_eq("ifu_rdata", i_rdata, 32'h0000_0413);
        check_eq("ifu_rlast", i_rlast, 1);
        check_eq("ifu_rresp", i_rresp, 0);
        step();
        @(negedge clk);
        check_eq("ifu_release", i_grant, 0);
        check_eq("ifu_rvalid_idle", i_rvalid, 0);

        // LSU write
        step();
        d_req = 1; d_wen = 1; d_awaddr = 32'h8000_1000; d_awvalid = 1;
        d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF; d_wvalid = 1; d_wlast = 1;
        @(negedge clk);
        check_eq("lsu_w_latency", d_grant, 0);
        step();
        @(negedge clk);
        check_eq("lsu_w_grant", d_grant, 1);
        check_eq("lsu_w_i_grant", i_grant, 0);
        check_eq("lsu_m_awaddr", m_awaddr, 32'h8000_1000);
        check_eq("lsu_m_awid", m_awid, 1);
        check_eq("lsu_m_wdata", m_wdata, 32'hDEAD_BEEF);
        check_eq("lsu_m_wstrb", m_wstrb, 4'hF);
        check_eq("lsu_m_arvalid", m_arvalid, 0);
        check_eq("lsu_i_arready", i_arready, 0);
        step(); d_awvalid = 0; d_wvalid = 0; d_req = 0;
        @(negedge clk);
        check_eq("lsu_bvalid", d_bvalid, 1);
        check_eq("lsu_bresp", d_bresp, 0);
        step();
        @(negedge clk);
        check_eq("lsu_w_release", d_grant, 0);
        d_wen = 0;

        // tie from reset release: IFU, idle, LSU, idle, IFU
        step(); resetn = 0;
        step(); step();
        resetn = 1; i_req = 1; i_arvalid = 1; d_req = 1; d_arvalid = 1;
        exp_ig = 8'b1000_0110;
        exp_dg = 8'b0011_0000;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check_eq($sformatf("tie_i_grant_c%0d", c), i_grant, exp_ig[c]);
            check_eq($sformatf("tie_d_grant_c%0d", c), d_grant, exp_dg[c]);
        end
        step(); i_req = 0; i_arvalid = 0; d_req = 0; d_arvalid = 0;
        step(); step();
        @(negedge clk);
        check_eq("tie_drain", {i_grant, d_grant}, 2'b00);

        // reset during an LSU read beat, then a normal LSU read
        step();
        d_req = 1; d_wen = 0; d_araddr = 32'h8000_2000; d_arvalid = 1; rd_data = 32'h0000_1234;
        step();
        @(negedge clk);
        check_eq("lsu_r_grant", d_grant, 1);
        check_eq("lsu_m_arid", m_arid, 1);
        check_eq("lsu_m_araddr", m_araddr, 32'h8000_2000);
        step(); d_arvalid = 0;
        @(negedge clk);
        check_eq("lsu_rvalid", d_rvalid, 1);
        check_eq("lsu_rdata", d_rdata, 32'h0000_1234);
        #2 resetn = 0;
        #1;
        check_eq("midrst_d_grant", d_grant, 0);
        check_eq("midrst_i_grant", i_grant, 0);
        check_eq("midrst_d_rvalid", d_rvalid, 0);
        check_eq("midrst_m_rready", m_rready, 1);
        step(); resetn = 1; d_arvalid = 1;
        @(negedge clk);
        check_eq("post_rst_idle", d_grant, 0);
        step();
        @(negedge clk);
        check_eq("post_rst_grant", d_grant, 1);
        step(); d_arvalid = 0; d_req = 0;
        @(negedge clk);
        check_eq("post_rst_rvalid", d_rvalid, 1);
        check_eq("post_rst_rdata", d_rdata, 32'h0000_1234);
        step();
        @(negedge clk);
        check_eq("post_rst_release", d_grant, 0);

        // watchdog on a silent slave
        step();
        slave_en = 0; i_rready = 0; i_req = 1; i_arvalid = 1;
        check_eq("wd_pre_timeout", timeout, 0);
        n = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (i_grant) n++;
            else if (n > 0) break;
        end
        check_eq("wd_granted_cycles", n, 255);
        check_eq("err_i_rvalid", i_rvalid, 1);
        check_eq("err_i_rresp", i_rresp, 2'b10);
        check_eq("err_i_rlast", i_rlast, 1);
        check_eq("err_timeout", timeout, 1);
        check_eq("err_m_arvalid", m_arvalid, 0);
        check_eq("err_grants", {i_grant, d_grant}, 2'b00);
        step(); i_req = 0; i_arvalid = 0;
        @(negedge clk);
        check_eq("err_held", i_rvalid, 1);
        step(); i_rready = 1;
        @(negedge clk);
        check_eq("err_until_ack", i_rvalid, 1);
        step();
        @(negedge clk);
        check_eq("err_exit_rvalid", i_rvalid, 0);
        check_eq("timeout_sticky", timeout, 1);
        step(); step();
        @(negedge clk);
        check_eq("timeout_sticky2", timeout, 1);
        resetn = 0;
        #1;
        check_eq("timeout_cleared", timeout, 0);
        step(); resetn = 1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
